// File: rtl/fa_response_checker.sv
// -----------------------------------------------------------------------------
// fa_response_checker
//
// Self-checking response monitor for a 1-bit full adder. On each sample strobe
// it compares the observed {carry,sum} against the golden full-adder function
// of the applied {a,b,c}. It counts mismatches with a saturating counter,
// captures the first failing sample, and records which of the 8 input vectors
// have been seen. The run ends when all 8 vectors are covered, or when a
// cycle-count timeout expires. At that point pass/fail is reported.
//
// Handshake: sample_en has no back-pressure. When it is high in a RUN cycle,
// that cycle's a/b/c/sum/carry are one checked sample. The sample is dropped
// if start is high in the same cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse: clear all results, enter RUN
//   sample_en         current a/b/c/sum/carry are valid this cycle
//   a, b, c           stimulus applied to the adder under test
//   sum, carry        response of the adder under test
//   busy / done       state is RUN / DONE
//   pass              valid while done: full coverage, zero errors, no timeout
//   timeout           sticky: RUN was left because the timeout expired
//   err_cnt           saturating count of mismatching samples
//   cov_mask          bit i set once vector {a,b,c}==i has been sampled
//   fail_valid        first failure captured
//   fail_vec          {a,b,c} of the first failing sample
//   fail_got          {carry,sum} of the first failing sample
//   state_dbg         current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module fa_response_checker #(
    parameter int ERR_W   = 8,
    parameter int TMO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       cov_mask,
    output logic             fail_valid,
    output logic [2:0]       fail_vec,
    output logic [1:0]       fail_got,
    output logic [1:0]       state_dbg
);

    // The timeout counter only has to reach TMO_CYC-1. A disabled timeout
    // (TMO_CYC == 0) still keeps a 1-bit counter so the code stays uniform.
    localparam int TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int TMO_LAST = (TMO_CYC > 0) ? (TMO_CYC - 1) : 0;
    localparam logic [TW-1:0]    TMO_LAST_V = TW'(TMO_LAST);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       cov_q, cov_d;
    logic             fv_q, fv_d;
    logic [2:0]       fvec_q, fvec_d;
    logic [1:0]       fgot_q, fgot_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    // Golden model and per-sample derived values.
    logic [2:0]       idx;
    logic [1:0]       exp_resp;
    logic [1:0]       got_resp;
    logic             mismatch;
    logic [7:0]       cov_upd;
    logic [ERR_W-1:0] err_inc;
    logic             completing;

    assign idx      = {a, b, c};
    assign exp_resp = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    assign got_resp = {carry, sum};
    assign mismatch = (got_resp != exp_resp);
    assign cov_upd  = cov_q | (8'b0000_0001 << idx);
    assign err_inc  = (err_q == ERR_MAX) ? err_q : (err_q + ERR_W'(1));

    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        err_d      = err_q;
        cov_d      = cov_q;
        fv_d       = fv_q;
        fvec_d     = fvec_q;
        fgot_d     = fgot_q;
        tcnt_d     = tcnt_q;
        completing = 1'b0;

        if (start) begin
            // Start has priority in every state. A sample in the same
            // cycle is discarded.
            state_d   = S_RUN;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            err_d     = '0;
            cov_d     = '0;
            fv_d      = 1'b0;
            fvec_d    = '0;
            fgot_d    = '0;
            tcnt_d    = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (sample_en) begin
                        cov_d = cov_upd;
                        if (mismatch) begin
                            err_d = err_inc;
                            if (!fv_q) begin
                                fv_d   = 1'b1;
                                fvec_d = idx;
                                fgot_d = got_resp;
                            end
                        end
                        if (cov_upd == 8'hFF) begin
                            // pass includes this sample's own result.
                            completing = 1'b1;
                            state_d    = S_DONE;
                            pass_d     = (err_d == '0);
                        end
                    end
                    // Coverage completion beats a simultaneous timeout.
                    if ((TMO_CYC != 0) && !completing && (tcnt_q == TMO_LAST_V)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE hold everything. sample_en is ignored.
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            cov_q     <= '0;
            fv_q      <= 1'b0;
            fvec_q    <= '0;
            fgot_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            cov_q     <= cov_d;
            fv_q      <= fv_d;
            fvec_q    <= fvec_d;
            fgot_q    <= fgot_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign err_cnt    = err_q;
    assign cov_mask   = cov_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;
    assign fail_got   = fgot_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// -----------------------------------------------------------------------------
// tb_fa_response_checker
//
// Three checker instances share one stimulus stream. They differ only in
// their parameters:
//   [0] default       ERR_W=8, TMO_CYC=1024
//   [1] saturation    ERR_W=2, timeout disabled
//   [2] short timeout ERR_W=8, TMO_CYC=16
// A run-level reference model per instance predicts every output after every
// clock. Directed scenarios cover the main cases and random traffic follows.
// -----------------------------------------------------------------------------
module tb_fa_response_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic start = 1'b0, sample_en = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, sum = 1'b0, carry = 1'b0;

    logic       busy_v[3], done_v[3], pass_v[3], tmo_v[3], fv_v[3];
    logic [7:0] cov_v[3];
    logic [2:0] fvec_v[3];
    logic [1:0] fgot_v[3];
    logic [1:0] st_v[3];
    logic [7:0] err_d, err_t;
    logic [1:0] err_s;

    fa_response_checker #(.ERR_W(8), .TMO_CYC(1024)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(tmo_v[0]),
        .err_cnt(err_d), .cov_mask(cov_v[0]), .fail_valid(fv_v[0]),
        .fail_vec(fvec_v[0]), .fail_got(fgot_v[0]), .state_dbg(st_v[0])
    );

    fa_response_checker #(.ERR_W(2), .TMO_CYC(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(tmo_v[1]),
        .err_cnt(err_s), .cov_mask(cov_v[1]), .fail_valid(fv_v[1]),
        .fail_vec(fvec_v[1]), .fail_got(fgot_v[1]), .state_dbg(st_v[1])
    );

    fa_response_checker #(.ERR_W(8), .TMO_CYC(16)) u_tmo (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .timeout(tmo_v[2]),
        .err_cnt(err_t), .cov_mask(cov_v[2]), .fail_valid(fv_v[2]),
        .fail_vec(fvec_v[2]), .fail_got(fgot_v[2]), .state_dbg(st_v[2])
    );

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 running, 2 finished. cyc counts RUN cycles since start.
    typedef struct {
        int         mode;
        int         err;
        logic [7:0] cov;
        logic       fv;
        logic [2:0] fvec;
        logic [1:0] fgot;
        logic       tmo;
        logic       pass;
        int         cyc;
    } model_t;

    model_t m[3];
    int     err_max[3] = '{255, 3, 255};
    int     tmo_cyc[3] = '{1024, 0, 16};
    string  nm[3]      = '{"dflt", "sat", "tmo"};

    int n_checks = 0;
    int n_errors = 0;

    function automatic model_t model_clear();
        model_t n;
        n.mode = 0; n.err = 0; n.cov = '0; n.fv = 1'b0; n.fvec = '0;
        n.fgot = '0; n.tmo = 1'b0; n.pass = 1'b0; n.cyc = 0;
        return n;
    endfunction

    // Correct response: carry/sum is simply the 2-bit count of ones.
    function automatic logic [1:0] good(input logic [2:0] v);
        int s;
        s = int'(v[2]) + int'(v[1]) + int'(v[0]);
        return s[1:0];
    endfunction

    function automatic model_t step(input model_t s, input int emax, input int tcyc,
                                    input logic st, input logic se,
                                    input logic [2:0] v, input logic [1:0] r);
        model_t n;
        bit     fin;
        n   = s;
        fin = 0;
        if (st) begin
            n = model_clear();
            n.mode = 1;
            return n;
        end
        if (s.mode == 1) begin
            if (se) begin
                if (r != good(v)) begin
                    if (n.err < emax) n.err = n.err + 1;
                    if (!n.fv) begin
                        n.fv = 1'b1; n.fvec = v; n.fgot = r;
                    end
                end
                n.cov[v] = 1'b1;
                if (n.cov == 8'hFF) begin
                    n.mode = 2; n.pass = (n.err == 0); fin = 1;
                end
            end
            n.cyc = n.cyc + 1;
            if (!fin && tcyc != 0 && n.cyc == tcyc) begin
                n.mode = 2; n.tmo = 1'b1; n.pass = 1'b0;
            end
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] err_of(input int k);
        case (k)
            0:       return 32'(err_d);
            1:       return 32'(err_s);
            default: return 32'(err_t);
        endcase
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check({nm[k], ".busy"},       32'(busy_v[k]), 32'(m[k].mode == 1));
            check({nm[k], ".done"},       32'(done_v[k]), 32'(m[k].mode == 2));
            check({nm[k], ".pass"},       32'(pass_v[k]), 32'(m[k].pass));
            check({nm[k], ".timeout"},    32'(tmo_v[k]),  32'(m[k].tmo));
            check({nm[k], ".err_cnt"},    err_of(k),      32'(m[k].err));
            check({nm[k], ".cov_mask"},   32'(cov_v[k]),  32'(m[k].cov));
            check({nm[k], ".fail_valid"}, 32'(fv_v[k]),   32'(m[k].fv));
            check({nm[k], ".fail_vec"},   32'(fvec_v[k]), 32'(m[k].fvec));
            check({nm[k], ".fail_got"},   32'(fgot_v[k]), 32'(m[k].fgot));
        end
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of stimulus, clock it, advance the models, compare.
    task automatic tick(input logic st, input logic se, input logic [2:0] v, input logic [1:0] r);
        start = st; sample_en = se;
        a = v[2]; b = v[1]; c = v[0];
        {carry, sum} = r;
        @(posedge clk);
        for (int k = 0; k < 3; k++) m[k] = step(m[k], err_max[k], tmo_cyc[k], st, se, v, r);
        #1;
        compare_all();
        start = 1'b0; sample_en = 1'b0;
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    endtask

    // Sample every vector once. Vector bad_idx (if 0..7) reports bad_resp.
    task automatic sweep(input int bad_idx, input logic [1:0] bad_resp);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 3'(i), (i == bad_idx) ? bad_resp : good(3'(i)));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < 3; k++) m[k] = model_clear();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // sample_en in IDLE is ignored.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 3'(i), 2'b11);
        check("idle_cov", 32'(cov_v[0]), 32'h0);

        // Correct exhaustive sweep.
        tick(1'b1, 1'b0, 3'd0, 2'b00);
        sweep(-1, 2'b00);
        check("sweep_done", 32'(done_v[0]), 32'd1);
        check("sweep_pass", 32'(pass_v[0]), 32'd1);
        check("sweep_cov",  32'(cov_v[0]),  32'hFF);
        repeat (2) idle_tick();

        // Single injected fault at idx 3. Start comes from DONE.
        tick(1'b1, 1'b0, 3'd0, 2'b00);
        check("restart_cov", 32'(cov_v[0]), 32'h0);
        sweep(3, 2'b01);
        check("fault_vec", 32'(fvec_v[0]), 32'h3);
        check("fault_got", 32'(fgot_v[0]), 32'h1);
        check("fault_err", 32'(err_d),     32'd1);
        check("fault_pass", 32'(pass_v[0]), 32'd0);

        // Multiple faults with saturation on the narrow instance.
        tick(1'b1, 1'b0, 3'd0, 2'b00);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 3'd7, 2'($urandom_range(0, 2)));
        sweep(-1, 2'b00);
        check("sat_err",  32'(err_s),      32'h3);
        check("sat_vec",  32'(fvec_v[1]),  32'h7);
        check("sat_pass", 32'(pass_v[1]),  32'd0);
        check("wide_err", 32'(err_d),      32'd5);

        // Timeout: only idx 0..6 are sampled.
        tick(1'b1, 1'b0, 3'd0, 2'b00);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 3'(i), good(3'(i)));
        for (int i = 0; i < 8; i++) idle_tick();
        check("tmo_not_yet", 32'(done_v[2]), 32'd0);
        idle_tick();
        check("tmo_done", 32'(done_v[2]), 32'd1);
        check("tmo_flag", 32'(tmo_v[2]),  32'd1);
        check("tmo_cov",  32'(cov_v[2]),  32'h7F);
        repeat (3) idle_tick();

        // start together with sample_en in RUN drops the sample.
        tick(1'b1, 1'b0, 3'd0, 2'b00);
        tick(1'b0, 1'b1, 3'd5, 2'b00);
        tick(1'b1, 1'b1, 3'd6, 2'b00);
        check("restart_drop_cov", 32'(cov_v[0]), 32'h0);
        check("restart_drop_err", 32'(err_d),    32'd0);

        // Random traffic. Responses are mostly correct.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] v;
            logic [1:0] r;
            v = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : good(v);
            tick(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), v, r);
        end

        // Asynchronous reset mid-RUN after 4 samples.
        tick(1'b1, 1'b0, 3'd0, 2'b00);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 3'(i), (i == 2) ? 2'b11 : good(3'(i)));
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) m[k] = model_clear();
        check("arst_busy", 32'(busy_v[0]), 32'd0);
        check("arst_cov",  32'(cov_v[0]),  32'h0);
        check("arst_err",  32'(err_d),     32'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) idle_tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fa_response_checker.md
Name: fa_response_checker

Overview:
- Self-checking response monitor for the 1-bit full adder.
- Consumes the stimulus the bench applies (a, b, c) and the DUT response (sum, carry) on a sample strobe.
- Compares the response against the golden full-adder function, counts mismatches, captures the first failure, and tracks coverage of all 8 input combinations.
- Reports pass/fail when coverage is complete or on timeout.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- TMO_CYC, 1024, clock cycles allowed in RUN before a forced timeout; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears all results and enters RUN
- sample_en  input  1  the current a/b/c/sum/carry are valid for checking this cycle
- a  input  1  DUT operand a
- b  input  1  DUT operand b
- c  input  1  DUT carry-in
- sum  input  1  DUT sum output
- carry  input  1  DUT carry output
- busy  output  1  high while in RUN
- done  output  1  high while in DONE
- pass  output  1  valid when done; 1 means full coverage, zero errors, no timeout
- timeout  output  1  sticky; set when RUN is exited by the timeout
- err_cnt  output  ERR_W  number of mismatching samples, saturates at all-ones
- cov_mask  output  8  bit i set once input vector {a,b,c}==i has been sampled
- fail_valid  output  1  a first failure has been captured
- fail_vec  output  3  {a,b,c} of the first failing sample
- fail_got  output  2  {carry,sum} of the first failing sample

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, pass, timeout, fail_valid = 0; err_cnt=0; cov_mask=0; fail_vec=0; fail_got=0; timeout counter=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 clears err_cnt, cov_mask, fail_*, timeout, pass and the timeout counter; next state is RUN.
  - sample_en is ignored.
- RUN (busy=1), per cycle with sample_en=1:
  - idx = {a,b,c}.
  - exp_sum = a^b^c; exp_carry = (a&b)|(a&c)|(b&c).
  - cov_mask[idx] is set next cycle.
  - On mismatch ({carry,sum} != {exp_carry,exp_sum}), err_cnt increments by 1, saturating at 2^ERR_W-1 with no wrap.
  - If fail_valid=0 at a mismatch, capture fail_vec=idx and fail_got={carry,sum}, and set fail_valid=1. Later mismatches never overwrite the capture.
  - Repeated samples of an already-covered vector are still checked and still counted.
- Completion:
  - When (cov_mask | onehot(idx)) == 8'hFF on a sampled cycle, next state is DONE.
  - pass = (err_cnt_next == 0), where err_cnt_next includes the completing sample's own result.
  - Latency: done rises exactly 1 cycle after the sample that completes coverage.
- Timeout:
  - The counter increments every RUN cycle, sampled or not, and clears on start.
  - When TMO_CYC != 0 and the counter reaches TMO_CYC-1 without completion, next state is DONE with timeout=1 and pass=0.
  - If completion and timeout occur in the same cycle, completion wins: timeout=0 and pass is computed normally.
- DONE (done=1):
  - All results hold.
  - sample_en is ignored.
  - start=1 clears results and re-enters RUN, identical to start from IDLE.
- start in RUN: restart. Results clear and state stays RUN. A sample_en in the same cycle is dropped and neither checked nor covered.
- Reset mid-RUN: immediate return to the reset values, independent of clk.
- No internal assumption on DUT settling; the driver asserts sample_en only after the inputs have been stable for at least one cycle.

Test Plan:
- Correct exhaustive sweep: start, then 8 samples idx 0..7 with correct responses -> cov_mask=8'hFF, done=1 one cycle after the 8th sample, pass=1, err_cnt=0, fail_valid=0.
- Single injected fault: sweep with idx 3 (a=0,b=1,c=1) reporting {carry,sum}=2'b01 -> err_cnt=1, fail_vec=3'b011, fail_got=2'b01, pass=0, done=1.
- Multiple faults plus saturation: ERR_W=2, 5 wrong samples of idx 7, then complete coverage -> err_cnt=2'b11, fail_vec=3'b111 from the first fault, pass=0.
- Timeout: TMO_CYC=16, only idx 0..6 sampled -> DONE after 16 RUN cycles, timeout=1, pass=0, cov_mask=8'h7F.
- Restart and ignore rules: start in DONE clears all results; sample_en while in IDLE leaves cov_mask=0; start together with sample_en in RUN leaves cov_mask=0 and err_cnt=0.
- Async reset mid-RUN after 4 samples: rst_n low -> busy=0, cov_mask=0, err_cnt=0 immediately, with no clk edge required.
